mux4_scanner: RTL and testbench

Sequential front-end for the 4:1 mux (`mux4`). On a start request it steps the mux select through channels 0..3, holding each select for a programmable settle time, and samples the mux output `y` for each channel. It then publishes the four samples as one parallel word with a one-cycle done strobe. It sits directly upstream of `mux4`, driving its `sel`, and consumes the mux's `y`.

---
 rtl/mux4_scan_pkg.sv | 9 +
 rtl/mux4.sv | 8 +
 rtl/mux4_scanner.sv | 75 +++++++
 tb/tb_mux4_scanner.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mux4_scan_pkg.sv
// mux4_scan_pkg: state encoding and sizing shared by the mux4 scanner
package mux4_scan_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t SCAN = 2'd1;
  localparam state_t DONE = 2'd2;
  localparam int NCH = 4;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mux4.sv
// mux4: single-bit 4:1 multiplexer fed by the scanner's select
module mux4 (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y
);
  assign y = d[sel];
endmodule

// File: rtl/mux4_scanner.sv
// mux4_scanner: steps mux4 select 0..3 with a settle delay and publishes the four samples atomically
module mux4_scanner
  import mux4_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           cont,
  input  logic           y,
  output logic [1:0]     sel,
  output logic           busy,
  output logic           done,
  output logic [NCH-1:0] q
);
  state_t state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] shadow_q, shadow_d;
  logic [NCH-1:0] q_q, q_d;
  logic last;
  assign last = cnt_q == CNT_W'(SETTLE - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      q_q      <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      q_q      <= q_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    q_d      = q_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SCAN;
        sel_d   = '0;
        cnt_d   = '0;
      end
      SCAN: if (!last) cnt_d = cnt_q + 1'b1;
      else begin
        cnt_d = '0;
        // the last channel goes straight into q so the word is never seen half-written
        if (sel_q == 2'd3) begin
          state_d = DONE;
          q_d     = {y, shadow_q};
        end else begin
          shadow_d[sel_q] = y;
          sel_d           = sel_q + 2'd1;
        end
      end
      DONE: if (start || cont) begin
        state_d = SCAN;
        sel_d   = '0;
        cnt_d   = '0;
      end else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign sel  = sel_q;
  assign busy = state_q == SCAN;
  assign done = state_q == DONE;
  assign q    = q_q;
endmodule

// File: tb/tb_mux4_scanner.sv
// tb_mux4_scanner: two scanners (SETTLE 1 and 3) with mux4, checked against a time-based scan model
module tb_mux4_scanner;
  logic clk = 0, rst_n = 0, start = 0, cont = 0;
  logic [3:0] d = '0;
  logic [1:0] sel1, sel3;
  logic y1, y3, busy1, busy3, done1, done3;
  logic [3:0] q1, q3;
  int checks = 0, errors = 0;
  bit act[2], mdone[2];
  int el[2];
  logic [3:0] samp[2], mq[2];
  logic [1:0] msel[2];
  typedef struct {logic [3:0] d; logic [3:0] q; int lat1; int lat3;} vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  mux4 m1 (.d(d), .sel(sel1), .y(y1));
  mux4 m3 (.d(d), .sel(sel3), .y(y3));
  mux4_scanner #(.SETTLE(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .y(y1),
    .sel(sel1), .busy(busy1), .done(done1), .q(q1));
  mux4_scanner #(.SETTLE(3)) u3 (.clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .y(y3),
    .sel(sel3), .busy(busy3), .done(done3), .q(q3));

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  // Scan as a timeline: elapsed edges since acceptance decide which channel is sampled when
  task automatic model_step();
    int s, ch;
    bit was;
    for (int j = 0; j < 2; j++) begin
      s = j ? 3 : 1;
      was = mdone[j];
      mdone[j] = 0;
      if (!rst_n) begin
        act[j] = 0; msel[j] = '0; mq[j] = '0;
      end else if (act[j]) begin
        ch = el[j] / s;
        if (el[j] % s == s - 1) samp[j][ch] = d[ch];
        if (el[j] == 4 * s - 1) begin
          act[j] = 0; mq[j] = samp[j]; mdone[j] = 1;
        end else begin
          el[j]++;
          msel[j] = 2'(el[j] / s);
        end
      end else if (start || (was && cont)) begin
        act[j] = 1; el[j] = 0; msel[j] = '0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("sel1", 32'(sel1), 32'(msel[0]));
    chk("busy1", 32'(busy1), 32'(act[0]));
    chk("done1", 32'(done1), 32'(mdone[0]));
    chk("q1", 32'(q1), 32'(mq[0]));
    chk("sel3", 32'(sel3), 32'(msel[1]));
    chk("busy3", 32'(busy3), 32'(act[1]));
    chk("done3", 32'(done3), 32'(mdone[1]));
    chk("q3", 32'(q3), 32'(mq[1]));
  endtask

  task automatic settle_idle();
    start = 0;
    cont = 0;
    repeat (15) tick();
  endtask

  initial begin
    int lat1, lat3, n, ndone, t_first, t_second;
    logic [3:0] qa, qb;
    vecs[0] = '{4'b1010, 4'b1010, 4, 12};
    vecs[1] = '{4'b0101, 4'b0101, 4, 12};
    vecs[2] = '{4'b0000, 4'b0000, 4, 12};
    vecs[3] = '{4'b1111, 4'b1111, 4, 12};
    vecs[4] = '{4'b0011, 4'b0011, 4, 12};
    vecs[5] = '{4'b1100, 4'b1100, 4, 12};
    tick();
    tick();
    chk("rst_q1", 32'(q1), 32'h0);
    chk("rst_busy3", 32'(busy3), 32'h0);
    rst_n = 1;
    tick();
    foreach (vecs[i]) begin
      d = vecs[i].d;
      start = 1;
      tick();
      start = 0;
      lat1 = -1;
      lat3 = -1;
      for (int c = 1; c <= 14; c++) begin
        tick();
        if (done1 && lat1 < 0) begin lat1 = c; chk("tbl_q1", 32'(q1), 32'(vecs[i].q)); end
        if (done3 && lat3 < 0) begin lat3 = c; chk("tbl_q3", 32'(q3), 32'(vecs[i].q)); end
      end
      chk("tbl_lat1", 32'(lat1), 32'(vecs[i].lat1));
      chk("tbl_lat3", 32'(lat3), 32'(vecs[i].lat3));
      settle_idle();
    end
    // continuous mode with d swapped while u1 sits on channel 1
    d = 4'b1010;
    cont = 1;
    start = 1;
    tick();
    start = 0;
    tick();
    chk("cont_sel1", 32'(sel1), 32'h1);
    d = 4'b0101;
    ndone = 0;
    t_first = -1;
    t_second = -1;
    qa = '0;
    qb = '0;
    for (int c = 2; c <= 20; c++) begin
      tick();
      if (done1) begin
        if (ndone == 0) begin t_first = c; qa = q1; end
        else if (ndone == 1) begin t_second = c; qb = q1; end
        ndone++;
      end
    end
    chk("cont_q_first", 32'(qa), 32'h4);
    chk("cont_q_second", 32'(qb), 32'h5);
    chk("cont_period", 32'(t_second - t_first), 32'd5);
    settle_idle();
    // start pulse while busy must be ignored
    d = 4'b0110;
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    chk("busy_sel1", 32'(sel1), 32'h2);
    start = 1;
    tick();
    start = 0;
    ndone = 0;
    qa = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done1) begin ndone++; qa = q1; end
    end
    chk("busy_ndone", 32'(ndone), 32'd1);
    chk("busy_q", 32'(qa), 32'h6);
    settle_idle();
    // asynchronous reset mid-scan after a completed 1010 scan
    d = 4'b1010;
    start = 1;
    tick();
    start = 0;
    repeat (12) tick();
    chk("pre_rst_q1", 32'(q1), 32'ha);
    d = 4'b0011;
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    chk("pre_rst_sel1", 32'(sel1), 32'h2);
    #2 rst_n = 0;
    #1;
    chk("arst_q1", 32'(q1), 32'h0);
    chk("arst_sel1", 32'(sel1), 32'h0);
    chk("arst_busy1", 32'(busy1), 32'h0);
    chk("arst_done1", 32'(done1), 32'h0);
    chk("arst_q3", 32'(q3), 32'h0);
    chk("arst_busy3", 32'(busy3), 32'h0);
    tick();
    rst_n = 1;
    d = 4'b1001;
    start = 1;
    tick();
    start = 0;
    n = -1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (done3 && n < 0) begin n = c; chk("post_rst_q3", 32'(q3), 32'h9); end
    end
    chk("post_rst_lat3", 32'(n), 32'd12);
    chk("post_rst_q1", 32'(q1), 32'h9);
    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      d = 4'($urandom);
      start = ($urandom_range(0, 7) == 0);
      cont = ($urandom_range(0, 5) == 0);
      tick();
    end
    settle_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
